// File: rtl/ct_l2c_prf_queue.sv
// ---------------------------------------------------------------------------
// ct_l2c_prf_queue
//   In-order prefetch request queue between the L2C prefetch address
//   generator and the CIU prefetch request port. Requests whose line address
//   is already queued, or was among the last HIST addresses issued, are
//   accepted but dropped and counted. Also produces the local clock-enable
//   and idle indications for the gated prefetch clock.
//
// Ports:
//   l2c_pref_clk       gated prefetch clock
//   cpurst_b           asynchronous active-low reset
//   pfu_prfq_vld/addr/prot   generator request (valid/ready with prfq_pfu_ready)
//   prfq_pfu_ready     queue accepts a request this cycle
//   l2c_ciu_prf_vld/addr/prot  head request to CIU
//   ciu_l2c_prf_ready  CIU accepts the head this cycle
//   prfq_flush         synchronous flush of queue and history
//   prfq_clk_en        keep-running request for the l2c_pref_clk gate
//   prfq_idle          queue empty and no generator request pending
//   prfq_drop_cnt      saturating count of dropped duplicates
// ---------------------------------------------------------------------------
module ct_l2c_prf_queue #(
  parameter int DEPTH = 4,
  parameter int HIST  = 4
) (
  input  logic        l2c_pref_clk,
  input  logic        cpurst_b,
  input  logic        pfu_prfq_vld,
  input  logic [33:0] pfu_prfq_addr,
  input  logic [2:0]  pfu_prfq_prot,
  output logic        prfq_pfu_ready,
  output logic        l2c_ciu_prf_vld,
  output logic [33:0] l2c_ciu_prf_addr,
  output logic [2:0]  l2c_ciu_prf_prot,
  input  logic        ciu_l2c_prf_ready,
  input  logic        prfq_flush,
  output logic        prfq_clk_en,
  output logic        prfq_idle,
  output logic [7:0]  prfq_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int HW = (HIST > 1) ? $clog2(HIST) : 1;

  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [HW-1:0]    r_hist_ptr;
  logic [7:0]       r_drop_cnt;

  logic [AW-1:0]    w_rd_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_accept;
  logic             w_dup;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic [DEPTH-1:0] w_ent_vld;
  logic [DEPTH-1:0] w_ent_hit;
  logic [33:0]      w_ent_addr [DEPTH];
  logic [2:0]       w_ent_prot [DEPTH];
  logic [HIST-1:0]  w_hist_hit;
  logic [33:0]      w_head_addr;
  logic [2:0]       w_head_prot;

  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_empty  = (r_rd_ptr == r_wr_ptr);
  assign w_full   = (w_rd_idx == w_wr_idx) && (r_rd_ptr[AW] != r_wr_ptr[AW]);

  // No same-cycle bypass: a full queue stays not-ready even while popping.
  assign prfq_pfu_ready = !w_full && !prfq_flush;
  assign w_accept       = pfu_prfq_vld && prfq_pfu_ready;

  // The head is still marked valid while it is being popped, so a request
  // matching it in the pop cycle is treated as a duplicate.
  assign w_dup  = (|w_ent_hit) || (|w_hist_hit);
  assign w_push = w_accept && !w_dup;
  assign w_drop = w_accept && w_dup;
  assign w_pop  = !w_empty && ciu_l2c_prf_ready;

  assign w_head_addr = w_ent_addr[w_rd_idx];
  assign w_head_prot = w_ent_prot[w_rd_idx];

  assign l2c_ciu_prf_vld  = !w_empty;
  assign l2c_ciu_prf_addr = w_empty ? 34'h0 : w_head_addr;
  assign l2c_ciu_prf_prot = w_empty ? 3'h0  : w_head_prot;

  assign prfq_clk_en   = pfu_prfq_vld || !w_empty || prfq_flush;
  assign prfq_idle     = w_empty && !pfu_prfq_vld;
  assign prfq_drop_cnt = r_drop_cnt;

  genvar gi;

  // FIFO entries: written at wr_ptr, valid cleared when popped.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic        r_vld;
      logic [33:0] r_addr;
      logic [2:0]  r_prot;

      always_ff @(posedge l2c_pref_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
          r_vld  <= 1'b0;
          r_addr <= 34'h0;
          r_prot <= 3'h0;
        end else if (prfq_flush) begin
          r_vld <= 1'b0;
        end else if (w_push && (w_wr_idx == AW'(gi))) begin
          r_vld  <= 1'b1;
          r_addr <= pfu_prfq_addr;
          r_prot <= pfu_prfq_prot;
        end else if (w_pop && (w_rd_idx == AW'(gi))) begin
          r_vld <= 1'b0;
        end
      end

      assign w_ent_vld[gi]  = r_vld;
      assign w_ent_addr[gi] = r_addr;
      assign w_ent_prot[gi] = r_prot;
      assign w_ent_hit[gi]  = r_vld && (r_addr == pfu_prfq_addr);
    end
  endgenerate

  // Issue history: round-robin record of the last HIST popped addresses.
  generate
    for (gi = 0; gi < HIST; gi++) begin : g_hist
      logic        r_vld;
      logic [33:0] r_addr;

      always_ff @(posedge l2c_pref_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
          r_vld  <= 1'b0;
          r_addr <= 34'h0;
        end else if (prfq_flush) begin
          r_vld <= 1'b0;
        end else if (w_pop && (r_hist_ptr == HW'(gi))) begin
          r_vld  <= 1'b1;
          r_addr <= w_head_addr;
        end
      end

      assign w_hist_hit[gi] = r_vld && (r_addr == pfu_prfq_addr);
    end
  endgenerate

  always_ff @(posedge l2c_pref_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_hist_ptr <= '0;
    end else if (prfq_flush) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_hist_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        if (r_hist_ptr == HW'(HIST - 1)) begin
          r_hist_ptr <= '0;
        end else begin
          r_hist_ptr <= r_hist_ptr + HW'(1);
        end
      end
    end
  end

  // Drop counter survives flush; only reset clears it.
  always_ff @(posedge l2c_pref_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_drop_cnt <= 8'h0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'h1;
    end
  end

endmodule

// File: tb/tb_ct_l2c_prf_queue.sv
// ---------------------------------------------------------------------------
// tb_ct_l2c_prf_queue
//   Directed bench for ct_l2c_prf_queue. Stimulus pushes the expected CIU
//   request onto exp_q when a non-duplicate is accepted; a monitor pops and
//   compares on every CIU handshake. Direct checks cover ready/idle/clk_en,
//   drop counter, flush and reset behaviour.
// ---------------------------------------------------------------------------
module tb_ct_l2c_prf_queue;

  logic        l2c_pref_clk;
  logic        cpurst_b;
  logic        pfu_prfq_vld;
  logic [33:0] pfu_prfq_addr;
  logic [2:0]  pfu_prfq_prot;
  logic        prfq_pfu_ready;
  logic        l2c_ciu_prf_vld;
  logic [33:0] l2c_ciu_prf_addr;
  logic [2:0]  l2c_ciu_prf_prot;
  logic        ciu_l2c_prf_ready;
  logic        prfq_flush;
  logic        prfq_clk_en;
  logic        prfq_idle;
  logic [7:0]  prfq_drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];

  ct_l2c_prf_queue #(.DEPTH(4), .HIST(4)) dut (
    .l2c_pref_clk      (l2c_pref_clk),
    .cpurst_b          (cpurst_b),
    .pfu_prfq_vld      (pfu_prfq_vld),
    .pfu_prfq_addr     (pfu_prfq_addr),
    .pfu_prfq_prot     (pfu_prfq_prot),
    .prfq_pfu_ready    (prfq_pfu_ready),
    .l2c_ciu_prf_vld   (l2c_ciu_prf_vld),
    .l2c_ciu_prf_addr  (l2c_ciu_prf_addr),
    .l2c_ciu_prf_prot  (l2c_ciu_prf_prot),
    .ciu_l2c_prf_ready (ciu_l2c_prf_ready),
    .prfq_flush        (prfq_flush),
    .prfq_clk_en       (prfq_clk_en),
    .prfq_idle         (prfq_idle),
    .prfq_drop_cnt     (prfq_drop_cnt)
  );

  initial l2c_pref_clk = 1'b0;
  always #5 l2c_pref_clk = ~l2c_pref_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one request until accepted (bounded); record it as expected
  // CIU traffic when it should survive the duplicate filter.
  task automatic push(input logic [33:0] a, input logic [2:0] p, input bit issue);
    bit ok;
    ok = 1'b0;
    pfu_prfq_vld  = 1'b1;
    pfu_prfq_addr = a;
    pfu_prfq_prot = p;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (prfq_pfu_ready) ok = 1'b1;
      else begin
        @(posedge l2c_pref_clk); #1;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_accept: addr %0h never accepted, ready got 0 expected 1", a);
    end else if (issue) begin
      exp_q.push_back({a, p});
    end
    $display("push addr=%0h prot=%0d expect_issue=%0d", a, p, issue);
    @(posedge l2c_pref_clk); #1;
    pfu_prfq_vld = 1'b0;
  endtask

  // Raise CIU ready and wait (bounded) for the queue to empty.
  task automatic drain();
    bit done;
    done = 1'b0;
    ciu_l2c_prf_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (!l2c_ciu_prf_vld) done = 1'b1;
      else begin
        @(posedge l2c_pref_clk); #1;
      end
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain: vld got 1 expected 0 within 40 cycles");
    end
    @(posedge l2c_pref_clk); #1;
  endtask

  // Monitor: every CIU handshake must match the oldest expected request.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge l2c_pref_clk);
      if (cpurst_b && l2c_ciu_prf_vld && ciu_l2c_prf_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL issue_unexpected: got addr %0h expected no request", l2c_ciu_prf_addr);
        end else begin
          e = exp_q.pop_front();
          $display("issue addr=%0h prot=%0d", l2c_ciu_prf_addr, l2c_ciu_prf_prot);
          if ({l2c_ciu_prf_addr, l2c_ciu_prf_prot} !== e) begin
            n_fail++;
            $display("FAIL issue_order: got %0h/%0d expected %0h/%0d",
                     l2c_ciu_prf_addr, l2c_ciu_prf_prot, e[36:3], e[2:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    cpurst_b          = 1'b1;
    pfu_prfq_vld      = 1'b0;
    pfu_prfq_addr     = 34'h0;
    pfu_prfq_prot     = 3'h0;
    ciu_l2c_prf_ready = 1'b0;
    prfq_flush        = 1'b0;
    #1 cpurst_b = 1'b0;
    #1;
    chk("rst_vld",   {63'h0, l2c_ciu_prf_vld}, 64'h0);
    chk("rst_addr",  {30'h0, l2c_ciu_prf_addr}, 64'h0);
    chk("rst_prot",  {61'h0, l2c_ciu_prf_prot}, 64'h0);
    chk("rst_ready", {63'h0, prfq_pfu_ready}, 64'h1);
    chk("rst_idle",  {63'h0, prfq_idle}, 64'h1);
    chk("rst_drop",  {56'h0, prfq_drop_cnt}, 64'h0);
    chk("rst_clken", {63'h0, prfq_clk_en}, 64'h0);
    @(posedge l2c_pref_clk); #1;
    cpurst_b = 1'b1;

    // Single request: accepted cycle 1, visible cycle 2, idle cycle 3.
    pfu_prfq_vld = 1'b1; pfu_prfq_addr = 34'h100; pfu_prfq_prot = 3'b011;
    #1;
    chk("t1_ready", {63'h0, prfq_pfu_ready}, 64'h1);
    chk("t1_idle_busy", {63'h0, prfq_idle}, 64'h0);
    chk("t1_clken", {63'h0, prfq_clk_en}, 64'h1);
    exp_q.push_back({34'h100, 3'b011});
    @(posedge l2c_pref_clk); #1;
    pfu_prfq_vld = 1'b0; ciu_l2c_prf_ready = 1'b1;
    #1;
    chk("t1_vld",  {63'h0, l2c_ciu_prf_vld}, 64'h1);
    chk("t1_addr", {30'h0, l2c_ciu_prf_addr}, 64'h100);
    chk("t1_prot", {61'h0, l2c_ciu_prf_prot}, 64'h3);
    @(posedge l2c_pref_clk); #1;
    ciu_l2c_prf_ready = 1'b0;
    #1;
    chk("t1_idle", {63'h0, prfq_idle}, 64'h1);
    chk("t1_vld_after", {63'h0, l2c_ciu_prf_vld}, 64'h0);

    cpurst_b = 1'b0; #1; cpurst_b = 1'b1;
    @(posedge l2c_pref_clk); #1;

    // Fill to full with CIU stalled; 5th request waits for the first pop.
    for (int i = 0; i < 4; i++) begin
      pfu_prfq_vld = 1'b1; pfu_prfq_addr = 34'h100 + 34'(i); pfu_prfq_prot = 3'(i);
      #1;
      chk("t2_fill_ready", {63'h0, prfq_pfu_ready}, 64'h1);
      exp_q.push_back({34'h100 + 34'(i), 3'(i)});
      @(posedge l2c_pref_clk); #1;
    end
    pfu_prfq_addr = 34'h104; pfu_prfq_prot = 3'd4;
    #1;
    chk("t2_full_ready", {63'h0, prfq_pfu_ready}, 64'h0);
    chk("t2_head_addr", {30'h0, l2c_ciu_prf_addr}, 64'h100);
    @(posedge l2c_pref_clk); #1;
    ciu_l2c_prf_ready = 1'b1;
    #1;
    chk("t2_nobypass_ready", {63'h0, prfq_pfu_ready}, 64'h0);
    @(posedge l2c_pref_clk); #1;
    #1;
    chk("t2_after_pop_ready", {63'h0, prfq_pfu_ready}, 64'h1);
    exp_q.push_back({34'h104, 3'd4});
    @(posedge l2c_pref_clk); #1;
    pfu_prfq_vld = 1'b0;
    drain();
    chk("t2_drop", {56'h0, prfq_drop_cnt}, 64'h0);

    // Duplicate against a queued entry, then against the history.
    ciu_l2c_prf_ready = 1'b0;
    push(34'h200, 3'd1, 1'b1);
    push(34'h200, 3'd1, 1'b0);
    #1;
    chk("t3_drop_q", {56'h0, prfq_drop_cnt}, 64'h1);
    chk("t3_head", {30'h0, l2c_ciu_prf_addr}, 64'h200);
    drain();
    ciu_l2c_prf_ready = 1'b0;
    push(34'h200, 3'd1, 1'b0);
    #1;
    chk("t3_drop_hist", {56'h0, prfq_drop_cnt}, 64'h2);
    chk("t3_vld", {63'h0, l2c_ciu_prf_vld}, 64'h0);

    // History depth: A ages out after B..E, E is still remembered.
    ciu_l2c_prf_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(34'h300 + 34'(i), 3'(i), 1'b1);
    drain();
    push(34'h300, 3'd0, 1'b1);
    drain();
    chk("t4_reissue_drop", {56'h0, prfq_drop_cnt}, 64'h2);
    push(34'h304, 3'd4, 1'b0);
    #1;
    chk("t4_hist_hit_drop", {56'h0, prfq_drop_cnt}, 64'h3);

    // Flush with three queued; head handshake in the flush cycle is issued.
    ciu_l2c_prf_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(34'h400 + 34'(i), 3'd2, 1'b1);
    ciu_l2c_prf_ready = 1'b1; prfq_flush = 1'b1;
    #1;
    chk("t5_flush_ready", {63'h0, prfq_pfu_ready}, 64'h0);
    chk("t5_flush_clken", {63'h0, prfq_clk_en}, 64'h1);
    @(posedge l2c_pref_clk); #1;
    prfq_flush = 1'b0; ciu_l2c_prf_ready = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_vld", {63'h0, l2c_ciu_prf_vld}, 64'h0);
    chk("t5_idle", {63'h0, prfq_idle}, 64'h1);
    push(34'h304, 3'd4, 1'b1);
    drain();
    chk("t5_drop", {56'h0, prfq_drop_cnt}, 64'h3);

    // Saturation: one queued entry, then a stream of duplicates of it.
    ciu_l2c_prf_ready = 1'b0;
    push(34'h500, 3'd5, 1'b1);
    pfu_prfq_vld = 1'b1; pfu_prfq_addr = 34'h500; pfu_prfq_prot = 3'd5;
    repeat (251) @(posedge l2c_pref_clk);
    #1;
    chk("t6_drop_254", {56'h0, prfq_drop_cnt}, 64'hFE);
    @(posedge l2c_pref_clk); #1;
    chk("t6_drop_255", {56'h0, prfq_drop_cnt}, 64'hFF);
    repeat (8) @(posedge l2c_pref_clk);
    #1;
    chk("t6_drop_sat", {56'h0, prfq_drop_cnt}, 64'hFF);

    // Asynchronous reset mid-stream, away from any clock edge.
    pfu_prfq_vld = 1'b0;
    cpurst_b = 1'b0;
    #1;
    exp_q.delete();
    chk("t7_vld",   {63'h0, l2c_ciu_prf_vld}, 64'h0);
    chk("t7_addr",  {30'h0, l2c_ciu_prf_addr}, 64'h0);
    chk("t7_prot",  {61'h0, l2c_ciu_prf_prot}, 64'h0);
    chk("t7_drop",  {56'h0, prfq_drop_cnt}, 64'h0);
    chk("t7_ready", {63'h0, prfq_pfu_ready}, 64'h1);
    chk("t7_idle",  {63'h0, prfq_idle}, 64'h1);
    @(posedge l2c_pref_clk); #1;
    cpurst_b = 1'b1;
    push(34'h500, 3'd6, 1'b1);
    drain();
    chk("final_exp_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
